// File: rtl/local_store.sv
// Single-port 128-bit quadword local store arbitrating DMA > load/store > fetch line bursts.
// Define IF_FLUSH_EN to add the if_flush port that aborts an in-progress fetch burst.
module local_store #(
  parameter int ADDR_W     = 7,
  parameter int LINE_BEATS = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ls_req,
  input  logic                          ls_we,
  input  logic [ADDR_W-1:0]             ls_addr,
  input  logic [127:0]                  ls_wdata,
  output logic                          ls_stall,
  output logic                          ls_rvalid,
  output logic [127:0]                  ls_rdata,
  input  logic                          if_req,
  input  logic [ADDR_W-1:0]             if_addr,
  output logic                          if_busy,
  output logic                          if_valid,
  output logic [$clog2(LINE_BEATS)-1:0] if_beat,
  output logic [127:0]                  if_data,
  output logic                          if_last,
  input  logic                          dma_req,
  input  logic                          dma_we,
  input  logic [ADDR_W-1:0]             dma_addr,
  output logic                          dma_busy,
  output logic                          dma_wbeat,
  input  logic [127:0]                  dma_wdata,
  output logic                          dma_rvalid,
  output logic [127:0]                  dma_rdata,
  output logic                          dma_last
`ifdef IF_FLUSH_EN
  ,
  input  logic                          if_flush
`endif
);
  localparam int BEAT_W = $clog2(LINE_BEATS);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BEATS - 1);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} eng_state_e;

  logic [127:0]      mem [DEPTH];
  eng_state_e        if_state_q, dma_state_q;
  logic [ADDR_W-1:0] if_base_q, dma_base_q;
  logic [BEAT_W-1:0] if_cnt_q, dma_cnt_q;
  logic              dma_we_q;

  logic              ls_rvalid_q, if_valid_q, if_last_q, dma_rvalid_q, dma_last_q;
  logic [127:0]      ls_rdata_q, if_data_q, dma_rdata_q;
  logic [BEAT_W-1:0] if_beat_q;

  logic              dma_gnt_s, ls_gnt_s, if_gnt_s, if_flush_s;
  logic              acc_we_s;
  logic [ADDR_W-1:0] acc_addr_s;
  logic [127:0]      acc_wdata_s, rd_s;

`ifdef IF_FLUSH_EN
  assign if_flush_s = if_flush;
`else
  assign if_flush_s = 1'b0;
`endif

  // Per-cycle grant and single array access port selection
  always_comb begin
    dma_gnt_s   = (dma_state_q == S_BURST);
    ls_gnt_s    = ls_req & ~dma_gnt_s;
    if_gnt_s    = (if_state_q == S_BURST) & ~dma_gnt_s & ~ls_req;
    acc_we_s    = 1'b0;
    acc_addr_s  = '0;
    acc_wdata_s = '0;
    if (dma_gnt_s) begin
      acc_addr_s  = dma_base_q | ADDR_W'(dma_cnt_q);
      acc_we_s    = dma_we_q;
      acc_wdata_s = dma_wdata;
    end else if (ls_gnt_s) begin
      acc_addr_s  = ls_addr;
      acc_we_s    = ls_we;
      acc_wdata_s = ls_wdata;
    end else if (if_gnt_s) begin
      acc_addr_s  = if_base_q | ADDR_W'(if_cnt_q);
    end else begin
      acc_addr_s  = '0;
    end
  end

  assign rd_s      = mem[acc_addr_s];
  assign ls_stall  = ls_req & dma_gnt_s;
  assign dma_wbeat = dma_gnt_s & dma_we_q;

  // Array write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (acc_we_s) begin
      mem[acc_addr_s] <= acc_wdata_s;
    end
  end

  // Fetch burst engine; requests are only sampled while idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_state_q <= S_IDLE;
      if_base_q  <= '0;
      if_cnt_q   <= '0;
    end else if (if_flush_s) begin
      if_state_q <= S_IDLE;
      if_cnt_q   <= '0;
    end else if (if_state_q == S_IDLE) begin
      if (if_req) begin
        if_state_q <= S_BURST;
        if_base_q  <= if_addr & ~LINE_MASK;
        if_cnt_q   <= '0;
      end
    end else if (if_gnt_s) begin
      if_cnt_q <= if_cnt_q + BEAT_W'(1);
      if (if_cnt_q == LAST_BEAT) begin
        if_state_q <= S_IDLE;
      end
    end
  end

  // DMA burst engine; direction is latched with the line base
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dma_state_q <= S_IDLE;
      dma_base_q  <= '0;
      dma_cnt_q   <= '0;
      dma_we_q    <= 1'b0;
    end else if (dma_state_q == S_IDLE) begin
      if (dma_req) begin
        dma_state_q <= S_BURST;
        dma_base_q  <= dma_addr & ~LINE_MASK;
        dma_cnt_q   <= '0;
        dma_we_q    <= dma_we;
      end
    end else begin
      dma_cnt_q <= dma_cnt_q + BEAT_W'(1);
      if (dma_cnt_q == LAST_BEAT) begin
        dma_state_q <= S_IDLE;
      end
    end
  end

  // Registered read data and valids, one cycle after the granted access
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ls_rvalid_q  <= 1'b0;
      ls_rdata_q   <= '0;
      if_valid_q   <= 1'b0;
      if_beat_q    <= '0;
      if_data_q    <= '0;
      if_last_q    <= 1'b0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
      dma_last_q   <= 1'b0;
    end else begin
      ls_rvalid_q  <= ls_gnt_s & ~ls_we;
      if (ls_gnt_s & ~ls_we) begin
        ls_rdata_q <= rd_s;
      end
      if_valid_q   <= if_gnt_s & ~if_flush_s;
      if_last_q    <= if_gnt_s & ~if_flush_s & (if_cnt_q == LAST_BEAT);
      if (if_gnt_s) begin
        if_beat_q <= if_cnt_q;
        if_data_q <= rd_s;
      end
      dma_rvalid_q <= dma_gnt_s & ~dma_we_q;
      dma_last_q   <= dma_gnt_s & ~dma_we_q & (dma_cnt_q == LAST_BEAT);
      if (dma_gnt_s & ~dma_we_q) begin
        dma_rdata_q <= rd_s;
      end
    end
  end

  assign ls_rvalid  = ls_rvalid_q;
  assign ls_rdata   = ls_rdata_q;
  assign if_busy    = (if_state_q == S_BURST);
  assign if_valid   = if_valid_q;
  assign if_beat    = if_beat_q;
  assign if_data    = if_data_q;
  assign if_last    = if_last_q;
  assign dma_busy   = (dma_state_q == S_BURST);
  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = dma_rdata_q;
  assign dma_last   = dma_last_q;

endmodule

// File: tb/tb_local_store.sv
// Randomized self-checking bench for local_store against a queue-based reference model.
module tb_local_store;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         ls_req = 1'b0, ls_we = 1'b0;
  logic [6:0]   ls_addr = '0;
  logic [127:0] ls_wdata = '0;
  logic         ls_stall, ls_rvalid;
  logic [127:0] ls_rdata;
  logic         if_req = 1'b0;
  logic [6:0]   if_addr = '0;
  logic         if_busy, if_valid, if_last;
  logic [2:0]   if_beat;
  logic [127:0] if_data;
  logic         dma_req = 1'b0, dma_we = 1'b0;
  logic [6:0]   dma_addr = '0;
  logic         dma_busy, dma_wbeat, dma_rvalid, dma_last;
  logic [127:0] dma_wdata = '0;
  logic [127:0] dma_rdata;
  logic         if_flush = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: array contents plus queues of pending beat addresses per engine
  logic [127:0] mem_m [0:127];
  logic [6:0]   if_q[$];
  logic [6:0]   dma_q[$];
  logic         m_dma_we = 1'b0;
  logic         e_ls_rvalid = 1'b0, e_if_valid = 1'b0, e_if_last = 1'b0;
  logic         e_dma_rvalid = 1'b0, e_dma_last = 1'b0;
  logic [2:0]   e_if_beat = '0;
  logic [127:0] e_ls_rdata = '0, e_if_data = '0, e_dma_rdata = '0;

  local_store #(.ADDR_W(7), .LINE_BEATS(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_stall(ls_stall), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .if_req(if_req), .if_addr(if_addr), .if_busy(if_busy), .if_valid(if_valid),
    .if_beat(if_beat), .if_data(if_data), .if_last(if_last),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_busy(dma_busy),
    .dma_wbeat(dma_wbeat), .dma_wdata(dma_wdata), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata), .dma_last(dma_last)
`ifdef IF_FLUSH_EN
    , .if_flush(if_flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the rules of one clock edge to the model using the inputs held at that edge
  task automatic model_edge();
    bit         if_idle, dma_idle;
    logic [6:0] a;
    if_idle  = (if_q.size() == 0);
    dma_idle = (dma_q.size() == 0);
    e_ls_rvalid = 1'b0; e_if_valid = 1'b0; e_if_last = 1'b0;
    e_dma_rvalid = 1'b0; e_dma_last = 1'b0;
    if (!dma_idle) begin
      a = dma_q.pop_front();
      if (m_dma_we) mem_m[a] = dma_wdata;
      else begin
        e_dma_rvalid = 1'b1; e_dma_rdata = mem_m[a]; e_dma_last = (a % 8 == 7);
      end
    end else if (ls_req) begin
      if (ls_we) mem_m[ls_addr] = ls_wdata;
      else begin
        e_ls_rvalid = 1'b1; e_ls_rdata = mem_m[ls_addr];
      end
    end else if (!if_idle) begin
      a = if_q.pop_front();
      if (!if_flush) begin
        e_if_valid = 1'b1; e_if_beat = 3'(a % 8); e_if_data = mem_m[a]; e_if_last = (a % 8 == 7);
      end
    end
    if (if_flush) if_q.delete();
    else if (if_idle && if_req)
      for (int k = 0; k < 8; k++) if_q.push_back(7'((if_addr / 8) * 8 + k));
    if (dma_idle && dma_req) begin
      m_dma_we = dma_we;
      for (int k = 0; k < 8; k++) dma_q.push_back(7'((dma_addr / 8) * 8 + k));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  // Pulse reset mid-cycle; outputs must clear immediately
  task automatic do_reset();
    #1 reset_n = 1'b0;
    if_q.delete(); dma_q.delete(); m_dma_we = 1'b0;
    e_ls_rvalid = 1'b0; e_ls_rdata = '0; e_if_valid = 1'b0; e_if_beat = '0; e_if_data = '0;
    e_if_last = 1'b0; e_dma_rvalid = 1'b0; e_dma_rdata = '0; e_dma_last = 1'b0;
    #1;
    cmp("rst_if_valid", 128'(if_valid), 128'd0);
    cmp("rst_if_busy", 128'(if_busy), 128'd0);
    #1 reset_n = 1'b1;
  endtask

  // Single compare process: every output against the model, away from the active edge
  always @(negedge clk) begin
    cmp("ls_stall", 128'(ls_stall), 128'(ls_req && dma_q.size() > 0));
    cmp("dma_wbeat", 128'(dma_wbeat), 128'(dma_q.size() > 0 && m_dma_we));
    cmp("if_busy", 128'(if_busy), 128'(if_q.size() > 0));
    cmp("dma_busy", 128'(dma_busy), 128'(dma_q.size() > 0));
    cmp("ls_rvalid", 128'(ls_rvalid), 128'(e_ls_rvalid));
    cmp("ls_rdata", ls_rdata, e_ls_rdata);
    cmp("if_valid", 128'(if_valid), 128'(e_if_valid));
    cmp("if_last", 128'(if_last), 128'(e_if_last));
    if (e_if_valid) begin
      cmp("if_beat", 128'(if_beat), 128'(e_if_beat));
      cmp("if_data", if_data, e_if_data);
    end
    cmp("dma_rvalid", 128'(dma_rvalid), 128'(e_dma_rvalid));
    cmp("dma_last", 128'(dma_last), 128'(e_dma_last));
    if (e_dma_rvalid) cmp("dma_rdata", dma_rdata, e_dma_rdata);
  end

  initial begin
    int cnt, gap;
    #2;
    cmp("reset_ls_rvalid", 128'(ls_rvalid), 128'd0);
    cmp("reset_ls_rdata", ls_rdata, 128'd0);
    cmp("reset_if_out", 128'({if_busy, if_valid, if_beat, if_last}), 128'd0);
    cmp("reset_dma_out", 128'({dma_busy, dma_rvalid, dma_last}), 128'd0);
    #10 reset_n = 1'b1;

    for (int a = 0; a < 128; a++) begin
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 7'(a);
      ls_wdata = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end

    ls_we = 1'b1; ls_addr = 7'd5; ls_wdata = {16{8'hA5}};
    tick();
    ls_we = 1'b0;
    tick();
    ls_req = 1'b0;
    cmp("lit_a5_rvalid", 128'(ls_rvalid), 128'd1);
    cmp("lit_a5_rdata", ls_rdata, {16{8'hA5}});

    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 7'h13;
    tick();
    dma_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dma_wdata = 128'(i);
      #1 cmp("lit_dma_wbeat", 128'(dma_wbeat), 128'd1);
      tick();
    end
    cmp("lit_dma_wr_done", 128'({dma_busy, dma_wbeat}), 128'd0);
    for (int i = 0; i < 8; i++) begin
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 7'(8'h10 + i);
      tick();
      cmp("lit_dma_wr_load", ls_rdata, 128'(i));
    end
    ls_req = 1'b0;

    if_req = 1'b1; if_addr = 7'h12;
    tick();
    if_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      cmp("lit_if_beat", 128'({if_valid, if_beat, if_last}), 128'({1'b1, 3'(k), k == 7}));
      cmp("lit_if_data", if_data, 128'(k));
    end
    tick();
    cmp("lit_if_end", 128'({if_valid, if_busy}), 128'd0);

    if_req = 1'b1; if_addr = 7'h10;
    tick();
    if_req = 1'b0;
    cnt = 0; gap = 0;
    for (int t = 0; t < 12; t++) begin
      ls_req = (t == 2 || t == 3); ls_we = 1'b0; ls_addr = 7'h20;
      tick();
      if (if_valid) begin
        cmp("lit_gap_order", 128'(if_beat), 128'(cnt));
        cnt++;
      end else if (cnt > 0 && cnt < 8) gap++;
    end
    ls_req = 1'b0;
    cmp("lit_gap_beats", 128'(cnt), 128'd8);
    cmp("lit_gap_len", 128'(gap), 128'd2);

    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 7'h10;
    tick();
    dma_req = 1'b0;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 7'd5;
    for (int i = 0; i < 8; i++) begin
      #1 cmp("lit_stall", 128'(ls_stall), 128'd1);
      tick();
      cmp("lit_dma_rd", 128'({dma_rvalid, dma_last}), 128'({1'b1, i == 7}));
      cmp("lit_dma_rdata", dma_rdata, 128'(i));
    end
    #1 cmp("lit_stall_end", 128'(ls_stall), 128'd0);
    tick();
    ls_req = 1'b0;
    cmp("lit_ls_after_dma", 128'({ls_rvalid, ls_rdata}), {1'b1, {16{8'hA5}}});

    if_req = 1'b1; if_addr = 7'h30;
    tick();
    if_req = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    cmp("lit_pre_rst_beat", 128'({if_valid, if_beat}), 128'({1'b1, 3'd4}));
    do_reset();
    for (int k = 0; k < 3; k++) tick();
    cmp("lit_post_rst", 128'({if_valid, if_busy}), 128'd0);

`ifdef IF_FLUSH_EN
    if_req = 1'b1; if_addr = 7'h40;
    tick();
    if_req = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0;
    cmp("lit_flush", 128'({if_valid, if_busy}), 128'd0);
    tick();
    cmp("lit_flush_after", 128'(if_valid), 128'd0);
`endif

    for (int c = 0; c < 3000; c++) begin
      ls_req    = ($urandom_range(0, 9) < 3);
      ls_we     = $urandom_range(0, 1) == 1;
      ls_addr   = 7'($urandom);
      ls_wdata  = {$urandom, $urandom, $urandom, $urandom};
      if_req    = ($urandom_range(0, 9) == 0);
      if_addr   = 7'($urandom);
      dma_req   = ($urandom_range(0, 9) == 0);
      dma_we    = $urandom_range(0, 1) == 1;
      dma_addr  = 7'($urandom);
      dma_wdata = {$urandom, $urandom, $urandom, $urandom};
`ifdef IF_FLUSH_EN
      if_flush  = ($urandom_range(0, 49) == 0);
`endif
      tick();
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/local_store.md
# local_store

Single-port quadword local store shared by the load/store unit, the instruction-fetch line buffer and the DMA engine. It sits directly downstream of the load/store unit:
- consumes the LS unit's address, write-select and store data;
- returns load data to it.

It also services 8-beat (128-byte) line bursts for instruction fetch and DMA. One array access is performed per cycle, with per-beat priority DMA > load/store > instruction fetch.

## Interface
- ADDR_W, 7, quadword address width (2^ADDR_W x 128-bit entries; 14 gives the full 256 kB LS)
- LINE_BEATS, 8, quadwords per burst line (fixed power of two; 3-bit beat index)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ls_req  in  1  load/store access request this cycle
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  quadword address
- ls_wdata  in  128  store data
- ls_stall  out  1  request not serviced this cycle; hold request
- ls_rvalid  out  1  load data valid
- ls_rdata  out  128  load data
- if_req  in  1  fetch line request
- if_addr  in  ADDR_W  fetch address; low 3 bits ignored
- if_busy  out  1  fetch burst in progress
- if_valid  out  1  fetch beat data valid
- if_beat  out  3  beat index of if_data
- if_data  out  128  fetch beat data
- if_last  out  1  final beat of line
- dma_req  in  1  DMA line request
- dma_we  in  1  1 = DMA write line into LS
- dma_addr  in  ADDR_W  line address; low 3 bits ignored
- dma_busy  out  1  DMA burst in progress
- dma_wbeat  out  1  write beat consumed this cycle; dma_wdata must be valid
- dma_wdata  in  128  DMA write beat data
- dma_rvalid  out  1  DMA read beat valid
- dma_rdata  out  128  DMA read beat data
- dma_last  out  1  final DMA read beat
- if_flush  in  1  abort fetch burst (present only with IF_FLUSH_EN)

## Operation
- Array contents are not reset. Registered read: the array is read at edge N and data is presented in cycle N+1.
- Each burst engine (IF, DMA) has states IDLE and BURST, a latched line base and a 3-bit beat counter.
- IDLE -> BURST at the edge where the request is high. That edge latches:
  - base = addr with the low 3 bits cleared;
  - beat = 0;
  - for DMA only, dma_we.
- Requests are ignored while that engine is in BURST.
- Per-cycle grant:
  1. DMA engine in BURST → DMA beat.
  2. Else ls_req → LS access.
  3. Else IF engine in BURST → IF beat.
  4. Else idle.
- ls_stall = ls_req & DMA beat granted (combinational).
- Granted beat:
  - access address = base | beat;
  - beat increments;
  - on beat 7 the engine returns to IDLE at that edge.
- Address arithmetic is ADDR_W bits. A line never crosses the array end because the base is aligned.
- DMA write beat: dma_wbeat = 1 combinationally; dma_wdata is written to base | beat.
- LS store: ls_wdata is written at ls_addr; there is no ls_rvalid.

## Timing
- Reset values of all outputs are 0:
  - ls_rvalid, ls_rdata, if_*, dma_rvalid, dma_rdata, dma_last, busy flags;
  - the engines go to IDLE with beat 0.
- Load granted in cycle N → ls_rvalid = 1 and ls_rdata in N+1. ls_rdata holds until the next load.
- Fetch beat granted in N → if_valid, if_beat, if_data in N+1; if_last = (if_beat == 7).
- DMA read beat granted in N → dma_rvalid and dma_rdata in N+1; dma_last on beat 7.
- Uncontended burst: request at edge E, beats at E+1..E+8, data at E+2..E+9, busy high E+1..E+8.
- Store then load to the same address in consecutive cycles returns the new data.
- Reset mid-burst aborts the burst: no further valids, and partial DMA writes remain in the array.
- Request asserted on the same edge the engine returns to IDLE: ignored; it must be re-sampled while IDLE.

## Configuration
- IF_FLUSH_EN defined:
  - if_flush exists;
  - if_flush high forces the IF engine to IDLE at the next edge;
  - it suppresses if_valid for any beat granted in the flush cycle;
  - a simultaneous if_req is ignored.
- IF_FLUSH_EN undefined: no port; fetch bursts always complete 8 beats.

## Test plan
- Store 128'hA5..A5 to addr 5, load addr 5 next cycle → ls_rvalid one cycle later, ls_rdata = 128'hA5..A5.
- DMA write line addr 0x13 (base 0x10) with data = beat index → dma_wbeat 8 consecutive cycles. Then load 0x10..0x17 returns 0..7.
- if_req addr 0x12 uncontended → if_valid 8 consecutive cycles, if_beat 0..7, data from 0x10..0x17, if_last on the 8th.
- Fetch burst with ls_req high on beats 2-3 → if_valid gap of 2 cycles, LS served without stall, all 8 beats still delivered in order.
- DMA read burst with ls_req held → ls_stall high 8 cycles, load serviced on the 9th, dma_last on the 8th dma_rvalid.
- reset_n low mid fetch burst (beat 4) → if_valid/if_busy 0 immediately and stay 0 after release. With IF_FLUSH_EN, if_flush at beat 3 → no further if_valid.
